// File: rtl/y86_pkg.sv
// Shared Y86 decode constants: instruction codes, status codes and register IDs.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVL = 4'h3;
  localparam logic [3:0] I_RMMOVL = 4'h4;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_OPL    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHL  = 4'hA;
  localparam logic [3:0] I_POPL   = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_INS = 2'b10;

  localparam logic [3:0] RNONE        = 4'hF;
  localparam logic [3:0] RESP_DEFAULT = 4'h4;

  typedef enum logic {
    S_RUN     = 1'b0,
    S_HALTED  = 1'b1
  } state_e;

endpackage

// File: rtl/id_fields.sv
// Combinational Y86 field extraction: format, length, validity, valC/valP and destinations.
module id_fields
  import y86_pkg::*;
#(
  parameter int         WORD_W  = 32,
  parameter int         INST_W  = 16 + WORD_W,
  parameter logic [3:0] RESP_ID = RESP_DEFAULT
) (
  input  logic [WORD_W-1:0] pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic [3:0]        icode_o,
  output logic [3:0]        ifun_o,
  output logic [3:0]        rA_o,
  output logic [3:0]        rB_o,
  output logic [3:0]        dstE_o,
  output logic [3:0]        dstM_o,
  output logic [WORD_W-1:0] valC_o,
  output logic [WORD_W-1:0] valP_o,
  output logic              need_regids_o,
  output logic              need_valC_o,
  output logic [1:0]        stat_o
);

  logic [3:0] icode, ifun, ra, rb;
  logic       valid, need_regids, need_valc;

  always_comb begin
    icode       = inst_i[7:4];
    ifun        = inst_i[3:0];
    need_regids = 1'b0;
    need_valc   = 1'b0;
    valid       = (ifun == 4'h0);
    case (icode)
      I_HALT, I_NOP, I_RET: begin end
      I_CMOVXX: begin need_regids = 1'b1; valid = (ifun <= 4'd6); end
      I_OPL:    begin need_regids = 1'b1; valid = (ifun <= 4'd3); end
      I_PUSHL, I_POPL: need_regids = 1'b1;
      I_IRMOVL, I_RMMOVL, I_MRMOVL: begin need_regids = 1'b1; need_valc = 1'b1; end
      I_JXX:    begin need_valc = 1'b1; valid = (ifun <= 4'd6); end
      I_CALL:   need_valc = 1'b1;
      default:  valid = 1'b0;
    endcase

    ra = need_regids ? inst_i[15:12] : RNONE;
    rb = need_regids ? inst_i[11:8]  : RNONE;

    // Invalid encodings leave a NOP bubble that still carries the INS status.
    icode_o       = I_NOP;
    ifun_o        = 4'h0;
    rA_o          = RNONE;
    rB_o          = RNONE;
    dstE_o        = RNONE;
    dstM_o        = RNONE;
    valC_o        = '0;
    valP_o        = '0;
    need_regids_o = 1'b0;
    need_valC_o   = 1'b0;
    stat_o        = STAT_INS;
    if (valid) begin
      icode_o       = icode;
      ifun_o        = ifun;
      rA_o          = ra;
      rB_o          = rb;
      need_regids_o = need_regids;
      need_valC_o   = need_valc;
      stat_o        = (icode == I_HALT) ? STAT_HLT : STAT_AOK;
      if (need_valc) valC_o = need_regids ? inst_i[16 +: WORD_W] : inst_i[8 +: WORD_W];
      valP_o = pc_i + WORD_W'(1) + WORD_W'(need_regids)
             + (need_valc ? WORD_W'(WORD_W / 8) : '0);
      case (icode)
        I_CMOVXX, I_IRMOVL, I_OPL:       dstE_o = rb;
        I_PUSHL, I_POPL, I_CALL, I_RET:  dstE_o = RESP_ID;
        default:                         dstE_o = RNONE;
      endcase
      if (icode == I_MRMOVL || icode == I_POPL) dstM_o = ra;
    end
  end

endmodule

// File: rtl/id_pipe.sv
// Decode stage register: valid/ready pipeline slot with stall/flush and a sticky halt FSM.
// Handshake: a beat moves when valid and ready are both 1 on a rising edge; valid never waits on ready.
module id_pipe
  import y86_pkg::*;
#(
  parameter int         WORD_W  = 32,
  parameter int         INST_W  = 16 + WORD_W,
  parameter logic [3:0] RESP_ID = RESP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] pc_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              stall,
  input  logic              flush,
  output logic [3:0]        icode_o,
  output logic [3:0]        ifun_o,
  output logic [3:0]        rA_o,
  output logic [3:0]        rB_o,
  output logic [3:0]        dstE_o,
  output logic [3:0]        dstM_o,
  output logic [WORD_W-1:0] valC_o,
  output logic [WORD_W-1:0] valP_o,
  output logic              need_regids_o,
  output logic              need_valC_o,
  output logic [1:0]        stat_o,
  output logic              halted_o
);

  localparam int OUT_W = 24 + 2 * WORD_W + 4;
  localparam logic [OUT_W-1:0] BUBBLE =
    {I_NOP, 4'h0, RNONE, RNONE, RNONE, RNONE, {(2 * WORD_W){1'b0}}, 2'b00, STAT_AOK};

  logic [3:0]        d_icode, d_ifun, d_ra, d_rb, d_dste, d_dstm;
  logic [WORD_W-1:0] d_valc, d_valp;
  logic              d_nr, d_nc;
  logic [1:0]        d_stat;
  logic [OUT_W-1:0]  dec, out_q, out_d;
  logic              valid_q, valid_d, xfer;
  state_e            state_q, state_d;

  id_fields #(.WORD_W(WORD_W), .INST_W(INST_W), .RESP_ID(RESP_ID)) u_fields (
    .pc_i          (pc_i),
    .inst_i        (inst_i),
    .icode_o       (d_icode),
    .ifun_o        (d_ifun),
    .rA_o          (d_ra),
    .rB_o          (d_rb),
    .dstE_o        (d_dste),
    .dstM_o        (d_dstm),
    .valC_o        (d_valc),
    .valP_o        (d_valp),
    .need_regids_o (d_nr),
    .need_valC_o   (d_nc),
    .stat_o        (d_stat)
  );

  assign dec      = {d_icode, d_ifun, d_ra, d_rb, d_dste, d_dstm, d_valc, d_valp, d_nr, d_nc, d_stat};
  assign in_ready = (state_q == S_RUN) && !stall && !flush && (!valid_q || out_ready);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    state_d = state_q;
    if (flush) begin
      valid_d = 1'b0;
      out_d   = BUBBLE;
    end else if (!stall) begin
      if (xfer) begin
        valid_d = 1'b1;
        out_d   = dec;
      end else if (valid_q && out_ready) begin
        valid_d = 1'b0;
        out_d   = BUBBLE;
      end
    end
    // Once HLT or INS is accepted nothing else may enter until reset.
    if (xfer && d_stat != STAT_AOK) state_d = S_HALTED;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      valid_q <= 1'b0;
      out_q   <= BUBBLE;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  assign {icode_o, ifun_o, rA_o, rB_o, dstE_o, dstM_o, valC_o, valP_o,
          need_regids_o, need_valC_o, stat_o} = out_q;
  assign out_valid = valid_q;
  assign halted_o  = (state_q == S_HALTED);

endmodule
